// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
//   Runs AES MixColumns over a full 128-bit state by time-multiplexing
//   NUM_UNITS single-column units over the four columns. Sits between
//   ShiftRows and AddRoundKey in the iterative round datapath. A bypass
//   flag sampled with the input handshake passes the state through
//   unchanged for the final round.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active-high
//     in_valid   in_state / in_bypass valid
//     in_ready   block can accept a state (IDLE only)
//     in_state   128-bit state, column c = [127-32c -: 32], row r byte
//                = [127-32c-8r -: 8]
//     in_bypass  1: skip MixColumns
//     out_valid  out_state holds a result
//     out_ready  consumer accepts the result
//     out_state  result, same byte ordering as in_state
//     busy       1 while a state is in flight (RUN or DONE)
// ---------------------------------------------------------------------------

// Single-column MixColumns. Input packs row0 in [31:24]; output returns
// row0 result in [7:0] (byte-reversed relative to the input).
module mix_column_unit (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // b_r = 2a_r ^ 3a_(r+1) ^ a_(r+2) ^ a_(r+3)
    assign b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign b1 = xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0;
    assign b2 = xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1;
    assign b3 = xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2;

    assign col_out = {b3, b2, b1, b0};

endmodule

module mix_columns_seq #(
    parameter int NUM_UNITS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(NUM_UNITS == 1 || NUM_UNITS == 2 || NUM_UNITS == 4)) begin : g_bad_num_units
        $error("mix_columns_seq: NUM_UNITS must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;

    logic [31:0]  unit_in  [NUM_UNITS];
    logic [31:0]  unit_out [NUM_UNITS];

    // MSB position of column c inside the 128-bit state.
    function automatic logic [6:0] col_base(input logic [1:0] c);
        return 7'd127 - {c, 5'b00000};
    endfunction

    // Units return row0 in the low byte; restore state order.
    function automatic logic [31:0] byte_rev(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        mix_column_unit u_col (
            .col_in  (unit_in[g]),
            .col_out (unit_out[g])
        );
    end

    // Column select: unit u works on column col_q + u.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_in[u] = work_q[col_base(col_q + 2'(u)) -: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_state;
                    col_d  = 2'd0;
                    state_d = in_bypass ? DONE : RUN;
                end
            end
            RUN: begin
                for (int u = 0; u < NUM_UNITS; u++) begin
                    work_d[col_base(col_q + 2'(u)) -: 32] = byte_rev(unit_out[u]);
                end
                // Two-bit index wraps to 0 once the last column is written.
                col_d = col_q + 2'(NUM_UNITS);
                if (col_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = work_q;

endmodule
